// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC holder and instruction fetch stage feeding the control unit
// Optional bus-timeout error state enabled by defining IFU_BUS_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int                ADDR_W         = 32,
    parameter logic [ADDR_W-1:0] RESET_PC       = '0
`ifdef IFU_BUS_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CYCLES = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              pc_ctrl,
    input  logic [ADDR_W-1:0] pc_target,
    output logic [31:0]       instr,
    output logic [3:0]        cond,
    output logic [1:0]        op,
    output logic [5:0]        funct,
    output logic [3:0]        rn,
    output logic [3:0]        rd,
    output logic [3:0]        rm,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic              fetch_err
);

`ifdef IFU_BUS_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERROR} state_t;
`else
    typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;
`endif

    state_t state, state_nxt;

    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_redirect;

    assign pc_seq      = pc + ADDR_W'(4);
    assign pc_redirect = pc_target & ~ADDR_W'(3);
    assign pc_plus8    = pc + ADDR_W'(8);
    assign imem_addr   = pc;

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rn    = instr[19:16];
    assign rd    = instr[15:12];
    assign rm    = instr[3:0];

`ifdef IFU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // Fires on the last allowed FETCH cycle; an ack in that cycle still wins.
    assign wait_expired = (state == FETCH) && !imem_ack &&
                          (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FETCH && !imem_ack && !wait_expired) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else if (state != FETCH) begin
                wait_cnt <= '0;
            end
            if (wait_expired) begin
                fetch_err <= 1'b1;
            end
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            instr <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state == ISSUE && instr_ready) begin
                pc <= pc_ctrl ? pc_redirect : pc_seq;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_nxt = ISSUE;
`ifdef IFU_BUS_TIMEOUT_EN
                end else if (wait_expired) begin
                    state_nxt = ERROR;
`endif
                end
            end
            ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_nxt = FETCH;
                end
            end
`ifdef IFU_BUS_TIMEOUT_EN
            ERROR: begin
                state_nxt = ERROR;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        pc_ctrl;
    logic [31:0] pc_target;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rm;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic        fetch_err;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_ctrl     (pc_ctrl),
        .pc_target   (pc_target),
        .instr       (instr),
        .cond        (cond),
        .op          (op),
        .funct       (funct),
        .rn          (rn),
        .rd          (rd),
        .rm          (rm),
        .pc          (pc),
        .pc_plus8    (pc_plus8),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        logic [31:0] word;
        logic [31:0] pc;
    } instr_exp_t;

    logic [31:0] addr_q[$];
    instr_exp_t  instr_q[$];
    int          pass_cnt  = 0;
    int          total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Monitor: fetch handshakes and retires are checked against the queues.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (imem_req === 1'b1 && imem_ack === 1'b1) begin
                if (addr_q.size() == 0) chk("unexpected_fetch", 32'd0, 32'd1);
                else chk("fetch_addr", imem_addr, addr_q.pop_front());
            end
            if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
                if (instr_q.size() == 0) begin
                    chk("unexpected_retire", 32'd0, 32'd1);
                end else begin
                    instr_exp_t e;
                    e = instr_q.pop_front();
                    chk("ret_instr", instr, e.word);
                    chk("ret_pc", pc, e.pc);
                    chk("ret_pc_plus8", pc_plus8, e.pc + 32'd8);
                    chk("ret_cond", {28'd0, cond}, {28'd0, e.word[31:28]});
                    chk("ret_op", {30'd0, op}, {30'd0, e.word[27:26]});
                    chk("ret_funct", {26'd0, funct}, {26'd0, e.word[25:20]});
                    chk("ret_rn", {28'd0, rn}, {28'd0, e.word[19:16]});
                    chk("ret_rd", {28'd0, rd}, {28'd0, e.word[15:12]});
                    chk("ret_rm", {28'd0, rm}, {28'd0, e.word[3:0]});
                end
            end
        end
    end

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (imem_req !== 1'b1) chk("req_wait_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int delay);
        wait_req();
        addr_q.push_back(exp_addr);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(posedge clk); #1;
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, exp_addr);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        chk("valid_after_ack", {31'd0, instr_valid}, 32'd1);
        chk("req_drop_issue", {31'd0, imem_req}, 32'd0);
        chk("instr_latched", instr, word);
    endtask

    task automatic do_stall(input logic [31:0] exp_pc, input logic [31:0] word, input int n);
        for (int i = 0; i < n; i++) begin
            instr_ready = 1'b0;
            pc_ctrl     = 1'b1;
            pc_target   = 32'h0000_0500;
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("stall_no_req", {31'd0, imem_req}, 32'd0);
            chk("stall_instr", instr, word);
            chk("stall_pc", pc, exp_pc);
        end
        pc_ctrl = 1'b0;
    endtask

    task automatic do_retire(input logic [31:0] exp_pc, input logic [31:0] word,
                             input logic redir, input logic [31:0] target);
        instr_q.push_back('{word, exp_pc});
        instr_ready = 1'b1;
        pc_ctrl     = redir;
        pc_target   = target;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        pc_ctrl     = 1'b0;
        pc_target   = $urandom;
        chk("valid_drop_retire", {31'd0, instr_valid}, 32'd0);
        chk("req_after_retire", {31'd0, imem_req}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        pc_ctrl     = 1'b0;
        pc_target   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_err", {31'd0, fetch_err}, 32'd0);
        rst = 1'b0;

        // First word acked immediately; fields hand-decoded.
        do_fetch(32'h0, 32'hE281_1001, 0);
        chk("f_cond", {28'd0, cond}, 32'hE);
        chk("f_op", {30'd0, op}, 32'h0);
        chk("f_funct", {26'd0, funct}, 32'h28);
        chk("f_rn", {28'd0, rn}, 32'h1);
        chk("f_rd", {28'd0, rd}, 32'h1);
        chk("f_rm", {28'd0, rm}, 32'h1);
        chk("f_pc_plus8", pc_plus8, 32'h8);
        do_retire(32'h0, 32'hE281_1001, 1'b0, 32'h0);

        // Stall with pc_ctrl asserted but not ready: pc must not move.
        do_fetch(32'h4, 32'hE082_3003, 0);
        do_stall(32'h4, 32'hE082_3003, 3);
        do_retire(32'h4, 32'hE082_3003, 1'b0, 32'h0);

        // Redirect with misaligned target.
        do_fetch(32'h8, 32'hE591_2000, 0);
        do_retire(32'h8, 32'hE591_2000, 1'b1, 32'h0000_0106);
        do_fetch(32'h104, 32'h1A00_0005, 0);
        do_retire(32'h104, 32'h1A00_0005, 1'b1, 32'hFFFF_FFFF);

        // Top-of-memory wrap.
        do_fetch(32'hFFFF_FFFC, 32'hEAFF_FFFE, 0);
        chk("wrap_pc_plus8", pc_plus8, 32'h0000_0004);
        do_retire(32'hFFFF_FFFC, 32'hEAFF_FFFE, 1'b0, 32'h0);

        // Slow memory: 5 wait cycles.
        do_fetch(32'h0, 32'hE3A0_0000, 5);
        do_retire(32'h0, 32'hE3A0_0000, 1'b0, 32'h0);

        // Reset during a stalled fetch at pc=4; late ack must be ignored.
        wait_req();
        chk("pre_rst_addr", imem_addr, 32'h4);
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_async_req", {31'd0, imem_req}, 32'd0);
        chk("rst_async_pc", pc, 32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        chk("refetch_req", {31'd0, imem_req}, 32'd1);
        chk("refetch_addr", imem_addr, 32'h0);
        do_fetch(32'h0, 32'hE1A0_F00E, 0);
        do_retire(32'h0, 32'hE1A0_F00E, 1'b0, 32'h0);

`ifdef IFU_BUS_TIMEOUT_EN
        // No ack: error after 16 wait cycles, sticky until reset.
        wait_req();
        repeat (15) begin
            @(posedge clk); #1;
            chk("to_req_held", {31'd0, imem_req}, 32'd1);
            chk("to_no_err", {31'd0, fetch_err}, 32'd0);
        end
        @(posedge clk); #1;
        chk("to_err", {31'd0, fetch_err}, 32'd1);
        chk("to_req_off", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("to_err_sticky", {31'd0, fetch_err}, 32'd1);
            chk("to_err_valid", {31'd0, instr_valid}, 32'd0);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        chk("to_err_clear", {31'd0, fetch_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        // Ack in the 16th wait cycle wins.
        wait_req();
        repeat (15) begin
            @(posedge clk); #1;
        end
        addr_q.push_back(32'h0);
        imem_ack   = 1'b1;
        imem_rdata = 32'hE352_0000;
        @(posedge clk); #1;
        imem_ack = 1'b0;
        chk("ack_wins_valid", {31'd0, instr_valid}, 32'd1);
        chk("ack_wins_err", {31'd0, fetch_err}, 32'd0);
        do_retire(32'h0, 32'hE352_0000, 1'b0, 32'h0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("addr_q_drained", addr_q.size(), 32'd0);
        chk("instr_q_drained", instr_q.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
